// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
// Optional perf counter signals are present only when PIPELINE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if;
  logic [4:0]  ID_rs_i;
  logic [4:0]  ID_rt_i;
  logic        EX_MemRead_i;
  logic [4:0]  EX_rt_i;
  logic        branch_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;

  logic        PC_write_o;
  logic        IFID_write_o;
  logic        IFID_flush_o;
  logic        IDEX_bubble_o;
  logic        EXMEM_write_o;
  logic        MEMWB_bubble_o;
  logic        mem_err_o;
  logic [1:0]  state_o;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [15:0] load_stall_cnt_o;
  logic [15:0] mem_stall_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  modport master (
    output ID_rs_i, ID_rt_i, EX_MemRead_i, EX_rt_i, branch_taken_i, mem_req_i, mem_ack_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, EXMEM_write_o,
           MEMWB_bubble_o, mem_err_o, state_o
`ifdef PIPELINE_CTRL_PERF_EN
    , input load_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o
`endif
  );

  modport slave (
    input  ID_rs_i, ID_rt_i, EX_MemRead_i, EX_rt_i, branch_taken_i, mem_req_i, mem_ack_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, EXMEM_write_o,
           MEMWB_bubble_o, mem_err_o, state_o
`ifdef PIPELINE_CTRL_PERF_EN
    , output load_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/stall controller: load-use stalls, branch flushes, memory waits.
// Define PIPELINE_CTRL_PERF_EN to add saturating 16-bit performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipeline_ctrl_if.slave  ctrl
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StMemWait   = 2'd1,
    StResetHold = 2'd2
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic load_use;
  logic timeout;
  logic mode_hold;
  logic mode_freeze;

  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble;

  always_comb begin
    load_use = ctrl.EX_MemRead_i && (ctrl.EX_rt_i != 5'd0) &&
               ((ctrl.EX_rt_i == ctrl.ID_rs_i) || (ctrl.EX_rt_i == ctrl.ID_rt_i));
    timeout  = (cnt_q >= TimeoutCnt);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mode_hold   = 1'b0;
    mode_freeze = 1'b0;
    if (rst_i) begin
      mode_hold = 1'b1;
      state_d   = StResetHold;
      cnt_d     = '0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        StResetHold: begin
          mode_hold = 1'b1;
          state_d   = StRun;
        end
        StRun: begin
          if (ctrl.mem_req_i && !ctrl.mem_ack_i) begin
            mode_freeze = 1'b1;
            state_d     = StMemWait;
            cnt_d       = '0;
          end
        end
        StMemWait: begin
          // Release cycle (ack or timeout) falls through to the normal hazard rules.
          if (ctrl.mem_ack_i || timeout) begin
            state_d = StRun;
            if (!ctrl.mem_ack_i) begin
              err_d = 1'b1;
            end
          end else begin
            mode_freeze = 1'b1;
            cnt_d       = cnt_q + 8'd1;
          end
        end
        default: begin
          mode_hold = 1'b1;
          state_d   = StResetHold;
        end
      endcase
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    if (mode_hold) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mode_freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (load_use) begin
      // Load-use beats a taken branch; ID holds so the branch is seen again next cycle.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (ctrl.branch_taken_i) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StResetHold;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ctrl.PC_write_o     = pc_we;
  assign ctrl.IFID_write_o   = ifid_we;
  assign ctrl.IFID_flush_o   = ifid_flush;
  assign ctrl.IDEX_bubble_o  = idex_bubble;
  assign ctrl.EXMEM_write_o  = exmem_we;
  assign ctrl.MEMWB_bubble_o = memwb_bubble;
  assign ctrl.mem_err_o      = err_q && !rst_i;
  assign ctrl.state_o        = rst_i ? StResetHold : state_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [15:0] load_cnt_q, mem_cnt_q, flush_cnt_q;
  logic        load_evt, mem_evt, flush_evt;

  assign load_evt  = !mode_hold && !mode_freeze && load_use;
  assign mem_evt   = mode_freeze;
  assign flush_evt = ifid_flush && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_cnt_q  <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_evt && (load_cnt_q != 16'hFFFF)) begin
        load_cnt_q <= load_cnt_q + 16'd1;
      end
      if (mem_evt && (mem_cnt_q != 16'hFFFF)) begin
        mem_cnt_q <= mem_cnt_q + 16'd1;
      end
      if (flush_evt && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign ctrl.load_stall_cnt_o = load_cnt_q;
  assign ctrl.mem_stall_cnt_o  = mem_cnt_q;
  assign ctrl.flush_cnt_o      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle reference model plus directed literal checks.
module tb_pipeline_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctrl  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control vector order: {PC_write, IFID_write, IFID_flush, IDEX_bubble, EXMEM_write, MEMWB_bubble}
  localparam logic [5:0] CtlHold   = 6'b001101;
  localparam logic [5:0] CtlFreeze = 6'b000001;
  localparam logic [5:0] CtlLoad   = 6'b000110;
  localparam logic [5:0] CtlBranch = 6'b111010;
  localparam logic [5:0] CtlNormal = 6'b110010;

  function automatic logic [5:0] run_ctl(input logic lu, input logic br);
    if (lu) return CtlLoad;
    if (br) return CtlBranch;
    return CtlNormal;
  endfunction

  // Reference model: remembers the request cycle rather than counting wait cycles.
  logic       m_hold = 1'b0;
  logic       m_wait = 1'b0;
  logic       m_err  = 1'b0;
  int         m_start = 0;
  int         cyc = 0;
  logic       e_lu, e_rel, e_err;
  logic [5:0] e_ctl;
  logic [1:0] e_st;
  logic [8:0] act_v, exp_v;

  always @(negedge clk) begin
    e_lu  = bus.EX_MemRead_i && (bus.EX_rt_i != 0) &&
            ((bus.EX_rt_i == bus.ID_rs_i) || (bus.EX_rt_i == bus.ID_rt_i));
    e_rel = 1'b0;
    e_err = rst ? 1'b0 : m_err;
    if (rst || m_hold) begin
      e_ctl = CtlHold;
      e_st  = 2'd2;
    end else if (m_wait) begin
      e_rel = bus.mem_ack_i || ((cyc - m_start) > T);
      e_st  = 2'd1;
      e_ctl = e_rel ? run_ctl(e_lu, bus.branch_taken_i) : CtlFreeze;
    end else begin
      e_st  = 2'd0;
      e_ctl = (bus.mem_req_i && !bus.mem_ack_i) ? CtlFreeze
                                                : run_ctl(e_lu, bus.branch_taken_i);
    end
    act_v = {bus.state_o, bus.mem_err_o, bus.PC_write_o, bus.IFID_write_o, bus.IFID_flush_o,
             bus.IDEX_bubble_o, bus.EXMEM_write_o, bus.MEMWB_bubble_o};
    exp_v = {e_st, e_err, e_ctl};
    chk("model{state,err,ctl}", {23'd0, act_v}, {23'd0, exp_v});

    if (rst) begin
      m_hold = 1'b1;
      m_wait = 1'b0;
      m_err  = 1'b0;
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if (m_wait) begin
      if (e_rel) begin
        m_wait = 1'b0;
        if (!bus.mem_ack_i) m_err = 1'b1;
      end
    end else if (bus.mem_req_i && !bus.mem_ack_i) begin
      m_wait  = 1'b1;
      m_start = cyc;
    end
    cyc++;
  end

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] ert, input logic br,
                       input logic req, input logic ack);
    rst                = r;
    bus.ID_rs_i        = rs;
    bus.ID_rt_i        = rt;
    bus.EX_MemRead_i   = mr;
    bus.EX_rt_i        = ert;
    bus.branch_taken_i = br;
    bus.mem_req_i      = req;
    bus.mem_ack_i      = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    // Reset: two cycles high, then one hold cycle
    chk("rst_state", 32'(bus.state_o), 32'd2);
    chk("rst_pc", 32'(bus.PC_write_o), 32'd0);
    chk("rst_memwb", 32'(bus.MEMWB_bubble_o), 32'd1);
    tick();
    idle();
    chk("hold_state", 32'(bus.state_o), 32'd2);
    chk("hold_pc", 32'(bus.PC_write_o), 32'd0);
    chk("hold_memwb", 32'(bus.MEMWB_bubble_o), 32'd1);
    tick();
    chk("run_state", 32'(bus.state_o), 32'd0);
    chk("run_pc", 32'(bus.PC_write_o), 32'd1);
    tick();

    // Load-use stall for one cycle, then clears
    drive(1'b0, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_ctl", 32'({bus.PC_write_o, bus.IFID_write_o, bus.IDEX_bubble_o}), 32'b001);
    chk("lu_exmem", 32'(bus.EXMEM_write_o), 32'd1);
    tick();
    drive(1'b0, 5'd5, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_after_pc", 32'(bus.PC_write_o), 32'd1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_r0_pc", 32'(bus.PC_write_o), 32'd1);
    chk("lu_r0_bubble", 32'(bus.IDEX_bubble_o), 32'd0);
    tick();

    // Load-use together with a taken branch
    drive(1'b0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("sim_flush0", 32'(bus.IFID_flush_o), 32'd0);
    chk("sim_pc0", 32'(bus.PC_write_o), 32'd0);
    tick();
    drive(1'b0, 5'd1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("sim_flush1", 32'(bus.IFID_flush_o), 32'd1);
    tick();
    idle();
    tick();

    // Memory wait with ack on cycle 3
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("mw_exmem0", 32'(bus.EXMEM_write_o), 32'd0);
      tick();
    end
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("mw_release", 32'({bus.EXMEM_write_o, bus.MEMWB_bubble_o}), 32'b10);
    tick();
    idle();
    chk("mw_state", 32'(bus.state_o), 32'd0);
    chk("mw_err", 32'(bus.mem_err_o), 32'd0);
    tick();

    // Timeout: request cycle plus T wait cycles frozen, release on the next one
    for (int i = 0; i <= T; i++) begin
      drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("to_frozen", 32'(bus.EXMEM_write_o), 32'd0);
      tick();
    end
    chk("to_release", 32'({bus.EXMEM_write_o, bus.MEMWB_bubble_o}), 32'b10);
    tick();
    idle();
    chk("to_state", 32'(bus.state_o), 32'd0);
    chk("to_err", 32'(bus.mem_err_o), 32'd1);
    tick();
    tick();
    chk("to_err_sticky", 32'(bus.mem_err_o), 32'd1);

    // Reset in the middle of a memory wait
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("mr_exmem", 32'(bus.EXMEM_write_o), 32'd0);
    chk("mr_err", 32'(bus.mem_err_o), 32'd0);
    tick();
    idle();
    chk("mr_hold", 32'(bus.state_o), 32'd2);
    tick();
    chk("mr_run", 32'(bus.state_o), 32'd0);
    tick();

`ifdef PIPELINE_CTRL_PERF_EN
    drive(1'b0, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b0, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    chk("perf_load", 32'(bus.load_stall_cnt_o), 32'd2);
    chk("perf_mem", 32'(bus.mem_stall_cnt_o), 32'd3);
    tick();
`endif

    // Pseudo-random sweep checked only by the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      tick();
    end
    idle();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the five-stage pipeline. It generates write-enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits from a small FSM. It sits beside the pipeline registers and drives their enable/clear inputs; no datapath values pass through it.

## Interface
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before forced exit; 1..255.
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous reset, active-high
- ID_rs_i  in  5  rs field of the instruction in ID
- ID_rt_i  in  5  rt field of the instruction in ID
- EX_MemRead_i  in  1  instruction in EX is a load
- EX_rt_i  in  5  destination of the load in EX
- branch_taken_i  in  1  branch in ID resolved taken
- mem_req_i  in  1  instruction in MEM accesses data memory
- mem_ack_i  in  1  data memory completes the access this cycle
- PC_write_o  out  1  PC load enable
- IFID_write_o  out  1  IF/ID load enable
- IFID_flush_o  out  1  IF/ID loads a NOP
- IDEX_bubble_o  out  1  ID/EX loads zeroed control (RegWrite, MemtoReg, MemRead, MemWrite = 0)
- EXMEM_write_o  out  1  EX/MEM load enable
- MEMWB_bubble_o  out  1  MEM/WB loads zeroed control (RegWrite_o_4 = MemtoReg_o_4 = 0)
- mem_err_o  out  1  sticky timeout flag
- state_o  out  2  current FSM state: 0 RUN, 1 MEM_WAIT, 2 RESET_HOLD

## Operation
- States:
  - RESET_HOLD: entered on rst_i.
  - RUN: normal operation.
  - MEM_WAIT: pipeline frozen on a data-memory access.
- RESET_HOLD:
  - Exits to RUN one cycle after rst_i deasserts.
  - Outputs in this state: all *_write_o = 0, IFID_flush_o = IDEX_bubble_o = MEMWB_bubble_o = 1.
- While rst_i is high:
  - Same outputs as RESET_HOLD.
  - mem_err_o = 0, wait counter = 0.
- RUN, priority high to low:
  1. mem_req_i & ~mem_ack_i: memory stall.
     - All *_write_o = 0, MEMWB_bubble_o = 1.
     - Next state MEM_WAIT, counter cleared to 0.
  2. Load-use, defined as EX_MemRead_i & (EX_rt_i != 0) & (EX_rt_i == ID_rs_i | EX_rt_i == ID_rt_i):
     - PC_write_o = IFID_write_o = 0, IDEX_bubble_o = 1.
     - EX/MEM and MEM/WB advance.
  3. branch_taken_i: IFID_flush_o = 1; all writes = 1.
  4. Otherwise: all writes = 1; flush and bubbles = 0.
- Load-use and branch together: load-use wins. The branch is re-evaluated next cycle because ID holds.
- MEM_WAIT:
  - Outputs identical to the RUN memory-stall case.
  - Counter increments each cycle.
  - On mem_ack_i: one cycle with all writes = 1 and MEMWB_bubble_o = 0 (the access retires). That same cycle also applies the load-use/branch rules. Next state RUN.
  - If the counter reaches MEM_TIMEOUT with no ack: set mem_err_o, release as if acked, return to RUN.
- mem_err_o is cleared only by rst_i.

## Timing
- Outputs are combinational (Mealy) from state and current inputs: stall and flush take effect with zero latency, on the same edge that would have loaded the stage.
- State, counter and mem_err_o are registered on posedge clk_i.
- Load-use stall lasts exactly 1 cycle. The bubble then reaches EX and the hazard clears.
- Memory stall of N cycles means ack arrives in cycle N after the request. The freeze lasts N cycles and the release occurs in cycle N.
- Timeout: release occurs exactly MEM_TIMEOUT cycles after entering MEM_WAIT.
- rst_i asserted mid-MEM_WAIT: next cycle is RESET_HOLD, the counter is discarded and no release cycle is emitted.

## Configuration
- PIPELINE_CTRL_PERF_EN defined adds three 16-bit outputs:
  - load_stall_cnt_o: cycles with a load-use stall.
  - mem_stall_cnt_o: cycles with MEM_WAIT outputs.
  - flush_cnt_o: cycles with IFID_flush_o.
- Counter behaviour: saturate at 16'hFFFF and clear on rst_i.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset: rst_i = 1 for 2 cycles then 0 → state_o = 2 during reset and the following cycle; RUN afterwards; PC_write_o = 0 and MEMWB_bubble_o = 1 throughout the hold.
- Load-use: EX_MemRead_i = 1, EX_rt_i = 5, ID_rs_i = 5 → one cycle PC_write_o = 0, IFID_write_o = 0, IDEX_bubble_o = 1. Same stimulus with EX_rt_i = 0 → no stall.
- Memory wait: mem_req_i = 1, ack after 3 cycles → EXMEM_write_o = 0 for 3 cycles; release in cycle 3 with MEMWB_bubble_o = 0; state_o back to 0.
- Timeout: MEM_TIMEOUT = 4, mem_req_i = 1, no ack → release after 4 cycles; mem_err_o = 1 and stays high until rst_i.
- Simultaneous: load-use and branch_taken_i together → stall cycle with IFID_flush_o = 0; next cycle IFID_flush_o = 1.
- PIPELINE_CTRL_PERF_EN: 2 load stalls + 3-cycle memory wait → load_stall_cnt_o = 2, mem_stall_cnt_o = 3.
